slink_pstate_ctrl: RTL and testbench
====================================

Name: slink_pstate_ctrl

Overview:
Idle-driven power-state scheduler that generates the S-Link low-power requests (p1_req/p2_req/p3_req) that the stack otherwise ties low. It monitors application TX/RX activity in the link clock domain and requests the deepest allowed Px state whose idle threshold has expired. It then holds that request while the link is in Px, and sequences exit on a wake event. It sits between the application layer and the slink core, alongside the APB application block.

Parameters:
IDLE_CNT_WIDTH, 16, width of idle counter and threshold inputs
REQ_TIMEOUT, 1024, cycles to wait in REQ for in_px_state before aborting (must be >=2)
STAT_WIDTH, 16, width of statistics counters (used only with the optional feature)

Ports:
link_clk  in  1  link clock; all logic on rising edge
link_reset  in  1  synchronous, active-high reset
cfg_en  in  1  enables automatic Px entry
cfg_max_state  in  2  deepest allowed state: 0 none, 1 P1, 2 P2, 3 P3
p1_idle_thresh  in  IDLE_CNT_WIDTH  idle cycles before P1; 0 disables P1
p2_idle_thresh  in  IDLE_CNT_WIDTH  idle cycles before P2; 0 disables P2
p3_idle_thresh  in  IDLE_CNT_WIDTH  idle cycles before P3; 0 disables P3
tx_sop  in  1  application TX start-of-packet (activity)
rx_valid  in  1  application RX valid (activity)
app_wake  in  1  application wake/exit request (level or pulse)
in_px_state  in  1  slink core reports Px entered
in_reset_state  in  1  slink core in reset/LTSSM reset state
p1_req  out  1  P1 request
p2_req  out  1  P2 request
p3_req  out  1  P3 request
tx_hold  out  1  application must not issue tx_sop while high
pstate  out  2  current/target Px (0 when ACTIVE)
req_timeout  out  1  one-cycle pulse on REQ abort

Behaviour:
- Reset values: all outputs 0; FSM = ACTIVE; idle_cnt = 0; target = 0; wake_pend = 0.
- Activity term: act = tx_sop | rx_valid | app_wake.
- idle_cnt:
  - Increments by 1 each ACTIVE cycle with act = 0 and cfg_en = 1; saturates at all-ones (no wrap).
  - Cleared when act = 1, when cfg_en = 0, on leaving EXIT, and on in_reset_state.
- Threshold compare: idle_cnt >= thresh, with thresh != 0. Candidate priority is P3 > P2 > P1, restricted to index <= cfg_max_state.
- ACTIVE state:
  - If cfg_en, cfg_max_state != 0, act = 0 and a candidate exists: latch target, go to REQ.
  - The corresponding pN_req rises on the next cycle (registered); tx_hold rises with it.
- REQ state:
  - Exactly one pN_req = 1, matching target; tx_hold = 1; pstate = target.
  - in_px_state = 1: go to IN_PX. If wake_pend is set, go straight to EXIT on the following cycle.
  - act during REQ sets wake_pend; the request is not withdrawn until entry completes or the request times out.
  - REQ_TIMEOUT cycles without in_px_state: drop req, pulse req_timeout, go to ACTIVE, clear idle_cnt and wake_pend.
- IN_PX state:
  - Request and tx_hold stay held.
  - app_wake, tx_sop, wake_pend or cfg_en = 0: go to EXIT; pN_req drops on the next cycle.
  - rx_valid is ignored here.
- EXIT state:
  - All pN_req = 0; tx_hold = 1.
  - When in_px_state = 0, go to ACTIVE with idle_cnt = 0. tx_hold falls on the same edge the FSM enters ACTIVE.
- cfg_en falling during REQ: go to EXIT.
- in_reset_state = 1 in any state: next cycle force ACTIVE, all reqs 0, tx_hold 0, counters and wake_pend cleared. This overrides every other event in the same cycle.
- Simultaneous in_px_state and timeout expiry in the same cycle: in_px_state wins.
- Changing thresholds mid-count takes effect on the next compare; no restart.
- Invariant: p1_req, p2_req and p3_req are mutually exclusive (one-hot or all zero) at all times.

Optional Feature:
SLINK_PSTATE_STATS_EN:
- When defined, adds three output ports p1_entries, p2_entries, p3_entries, each STAT_WIDTH wide, plus a timeout_count port of STAT_WIDTH.
- pN_entries increments on each REQ to IN_PX transition for that state; timeout_count increments on each req_timeout pulse.
- All four counters saturate, and are cleared by link_reset only (not by in_reset_state).
- When undefined, these ports and their registers are absent; all other behaviour is identical.

Test Plan:
- P1 entry: cfg_en = 1, max = 1, p1_thresh = 10, no activity. Required: p1_req rises 11-12 cycles after reset release. Drive in_px_state = 1 and pulse app_wake. Required: p1_req falls the next cycle. Drop in_px_state. Required: tx_hold falls and pstate = 0.
- Priority: thresholds 5/20/40, max = 2, idle 60 cycles. Required: only p1_req rises, at idle count 5; after aborting via timeout and re-idling, still only P1 is requested. With max = 3, p1_thresh = 0, p2_thresh = 0, p3_thresh = 40: p3_req rises at count 40.
- Timeout: REQ_TIMEOUT = 16, in_px_state held 0. Required: req_timeout pulses for exactly one cycle 16 cycles after req rise; req = 0; idle count restarts from 0.
- Wake during REQ: tx_sop pulse 2 cycles after p2_req rises, then in_px_state = 1 at cycle 5. Required: IN_PX for one cycle, then p2_req falls. Never more than one req high.
- Reset mid-operation: in IN_PX, assert in_reset_state for one cycle. Required: next cycle all reqs = 0, tx_hold = 0, pstate = 0. With SLINK_PSTATE_STATS_EN defined, pN_entries is retained.
- Activity suppression: rx_valid every 8 cycles with p1_thresh = 10. Required: no request ever. Also check idle count saturation: p1_thresh = 0, IDLE_CNT_WIDTH = 4, idle 40 cycles; idle_cnt holds at 15.

Source files
------------

// File: rtl/slink_pstate_ctrl.sv
// slink_pstate_ctrl
//   Idle-driven power-state scheduler for the S-Link core. Watches application
//   TX/RX activity in the link clock domain, requests the deepest allowed Px
//   state whose idle threshold has expired, holds the request while the core
//   sits in Px, and sequences the exit on a wake event.
//
//   Optional build macro: SLINK_PSTATE_STATS_EN adds saturating entry and
//   timeout statistics counters (cleared by link_reset only).
//
// Ports
//   link_clk, link_reset          clock, synchronous active-high reset
//   cfg_en, cfg_max_state         automatic entry enable, deepest allowed Px
//   p1/p2/p3_idle_thresh          idle cycles before Px (0 disables that Px)
//   tx_sop, rx_valid, app_wake    application activity / wake
//   in_px_state, in_reset_state   core status
//   p1_req, p2_req, p3_req        one-hot Px requests
//   tx_hold                       application must not issue tx_sop
//   pstate                        current/target Px, 0 when active
//   req_timeout                   one-cycle pulse when a request is aborted
//   p1/p2/p3_entries, timeout_count  statistics (SLINK_PSTATE_STATS_EN only)

module slink_pstate_ctrl #(
  parameter int IDLE_CNT_WIDTH = 16,
  parameter int REQ_TIMEOUT    = 1024,
  parameter int STAT_WIDTH     = 16
) (
  input  logic                      link_clk,
  input  logic                      link_reset,
  input  logic                      cfg_en,
  input  logic [1:0]                cfg_max_state,
  input  logic [IDLE_CNT_WIDTH-1:0] p1_idle_thresh,
  input  logic [IDLE_CNT_WIDTH-1:0] p2_idle_thresh,
  input  logic [IDLE_CNT_WIDTH-1:0] p3_idle_thresh,
  input  logic                      tx_sop,
  input  logic                      rx_valid,
  input  logic                      app_wake,
  input  logic                      in_px_state,
  input  logic                      in_reset_state,
  output logic                      p1_req,
  output logic                      p2_req,
  output logic                      p3_req,
  output logic                      tx_hold,
  output logic [1:0]                pstate,
  output logic                      req_timeout
`ifdef SLINK_PSTATE_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]     p1_entries,
  output logic [STAT_WIDTH-1:0]     p2_entries,
  output logic [STAT_WIDTH-1:0]     p3_entries,
  output logic [STAT_WIDTH-1:0]     timeout_count
`endif
);

  localparam int TMR_W = (REQ_TIMEOUT > 2) ? $clog2(REQ_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REQ_TIMEOUT - 1);

  if (REQ_TIMEOUT < 2 || STAT_WIDTH < 1) begin : g_param_check
    $error("slink_pstate_ctrl: REQ_TIMEOUT must be >= 2 and STAT_WIDTH >= 1");
  end

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_REQ    = 2'd1,
    ST_IN_PX  = 2'd2,
    ST_EXIT   = 2'd3
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [IDLE_CNT_WIDTH-1:0] idle_cnt;
  logic [1:0]                target;
  logic                      wake_pend;
  logic [TMR_W-1:0]          req_tmr;

  logic                      act;
  logic [1:0]                cand;
  logic                      tmr_expired;
  logic                      timeout_hit;
  logic                      leave_exit;

  function automatic logic [IDLE_CNT_WIDTH-1:0] sat_idle_inc(
    input logic [IDLE_CNT_WIDTH-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign act         = tx_sop | rx_valid | app_wake;
  assign tmr_expired = (req_tmr == TMR_LAST);
  assign leave_exit  = (state == ST_EXIT) && (state_nxt == ST_ACTIVE);

  // Later assignments win, so the deepest expired state allowed by
  // cfg_max_state becomes the candidate.
  always_comb begin
    cand = 2'd0;
    if (cfg_max_state >= 2'd1 && p1_idle_thresh != '0 && idle_cnt >= p1_idle_thresh)
      cand = 2'd1;
    if (cfg_max_state >= 2'd2 && p2_idle_thresh != '0 && idle_cnt >= p2_idle_thresh)
      cand = 2'd2;
    if (cfg_max_state == 2'd3 && p3_idle_thresh != '0 && idle_cnt >= p3_idle_thresh)
      cand = 2'd3;
  end

  // ---- FSM: state register ----
  always_ff @(posedge link_clk) begin
    if (link_reset) state <= ST_ACTIVE;
    else            state <= state_nxt;
  end

  // ---- FSM: next-state logic ----
  // in_reset_state overrides everything; in REQ, cfg_en loss beats core entry,
  // and core entry beats a coincident timeout expiry.
  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    if (in_reset_state) begin
      state_nxt = ST_ACTIVE;
    end else begin
      unique case (state)
        ST_ACTIVE: begin
          if (cfg_en && cfg_max_state != 2'd0 && !act && cand != 2'd0)
            state_nxt = ST_REQ;
        end
        ST_REQ: begin
          if (!cfg_en) begin
            state_nxt = ST_EXIT;
          end else if (in_px_state) begin
            state_nxt = ST_IN_PX;
          end else if (tmr_expired) begin
            state_nxt   = ST_ACTIVE;
            timeout_hit = 1'b1;
          end
        end
        ST_IN_PX: begin
          // rx_valid alone does not wake the link from Px.
          if (app_wake || tx_sop || wake_pend || !cfg_en)
            state_nxt = ST_EXIT;
        end
        ST_EXIT: begin
          if (!in_px_state)
            state_nxt = ST_ACTIVE;
        end
        default: state_nxt = ST_ACTIVE;
      endcase
    end
  end

  // ---- Control registers: idle counter, target, wake, request timer ----
  always_ff @(posedge link_clk) begin
    if (link_reset || in_reset_state) begin
      idle_cnt    <= '0;
      target      <= 2'd0;
      wake_pend   <= 1'b0;
      req_tmr     <= '0;
      req_timeout <= 1'b0;
    end else begin
      if (act || !cfg_en || leave_exit || timeout_hit)
        idle_cnt <= '0;
      else if (state == ST_ACTIVE)
        idle_cnt <= sat_idle_inc(idle_cnt);

      if (state == ST_ACTIVE && state_nxt == ST_REQ)
        target <= cand;

      // Activity while the request is outstanding is remembered so the link
      // leaves Px right after entry instead of withdrawing mid-handshake.
      if (state_nxt == ST_ACTIVE)
        wake_pend <= 1'b0;
      else if (state == ST_REQ && act)
        wake_pend <= 1'b1;

      if (state != ST_REQ)
        req_tmr <= '0;
      else if (!tmr_expired)
        req_tmr <= req_tmr + 1'b1;

      req_timeout <= timeout_hit;
    end
  end

  // ---- FSM: output decode ----
  always_comb begin
    p1_req  = 1'b0;
    p2_req  = 1'b0;
    p3_req  = 1'b0;
    tx_hold = (state != ST_ACTIVE);
    pstate  = (state == ST_ACTIVE) ? 2'd0 : target;
    if (state == ST_REQ || state == ST_IN_PX) begin
      p1_req = (target == 2'd1);
      p2_req = (target == 2'd2);
      p3_req = (target == 2'd3);
    end
  end

`ifdef SLINK_PSTATE_STATS_EN
  logic px_entry;

  function automatic logic [STAT_WIDTH-1:0] sat_stat_inc(
    input logic [STAT_WIDTH-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign px_entry = (state == ST_REQ) && (state_nxt == ST_IN_PX);

  // ---- Statistics: survive in_reset_state, cleared by link_reset only ----
  always_ff @(posedge link_clk) begin
    if (link_reset) begin
      p1_entries    <= '0;
      p2_entries    <= '0;
      p3_entries    <= '0;
      timeout_count <= '0;
    end else begin
      if (px_entry) begin
        case (target)
          2'd1:    p1_entries <= sat_stat_inc(p1_entries);
          2'd2:    p2_entries <= sat_stat_inc(p2_entries);
          2'd3:    p3_entries <= sat_stat_inc(p3_entries);
          default: ;
        endcase
      end
      if (timeout_hit)
        timeout_count <= sat_stat_inc(timeout_count);
    end
  end
`endif

endmodule

// File: tb/tb_slink_pstate_ctrl.sv
module tb_slink_pstate_ctrl;
  localparam int W = 16;
  localparam int T = 16;
  localparam int IDLE_MAX = (1 << W) - 1;

  logic link_clk = 1'b0;
  always #5 link_clk = ~link_clk;

  logic         link_reset = 1'b1;
  logic         cfg_en = 1'b0;
  logic [1:0]   cfg_max_state = 2'd0;
  logic [W-1:0] p1_th = '0, p2_th = '0, p3_th = '0;
  logic         tx_sop = 1'b0, rx_valid = 1'b0, app_wake = 1'b0;
  logic         in_px_state = 1'b0, in_reset_state = 1'b0;
  logic         p1_req, p2_req, p3_req, tx_hold, req_timeout;
  logic [1:0]   pstate;

  logic         s_reset = 1'b1;
  logic         s_p1, s_p2, s_p3, s_hold, s_tout;
  logic [1:0]   s_pstate;

`ifdef SLINK_PSTATE_STATS_EN
  logic [15:0]  p1_entries, p2_entries, p3_entries, timeout_count;
  logic [15:0]  s_e1, s_e2, s_e3, s_tc;
`endif

  slink_pstate_ctrl #(.IDLE_CNT_WIDTH(W), .REQ_TIMEOUT(T), .STAT_WIDTH(16)) dut (
    .link_clk(link_clk), .link_reset(link_reset), .cfg_en(cfg_en),
    .cfg_max_state(cfg_max_state), .p1_idle_thresh(p1_th),
    .p2_idle_thresh(p2_th), .p3_idle_thresh(p3_th), .tx_sop(tx_sop),
    .rx_valid(rx_valid), .app_wake(app_wake), .in_px_state(in_px_state),
    .in_reset_state(in_reset_state), .p1_req(p1_req), .p2_req(p2_req),
    .p3_req(p3_req), .tx_hold(tx_hold), .pstate(pstate),
    .req_timeout(req_timeout)
`ifdef SLINK_PSTATE_STATS_EN
    , .p1_entries(p1_entries), .p2_entries(p2_entries),
    .p3_entries(p3_entries), .timeout_count(timeout_count)
`endif
  );

  // Narrow-counter instance, always idle with every threshold disabled.
  slink_pstate_ctrl #(.IDLE_CNT_WIDTH(4), .REQ_TIMEOUT(T), .STAT_WIDTH(16)) u_sat (
    .link_clk(link_clk), .link_reset(s_reset), .cfg_en(1'b1),
    .cfg_max_state(2'd3), .p1_idle_thresh(4'd0), .p2_idle_thresh(4'd0),
    .p3_idle_thresh(4'd0), .tx_sop(1'b0), .rx_valid(1'b0), .app_wake(1'b0),
    .in_px_state(1'b0), .in_reset_state(1'b0), .p1_req(s_p1), .p2_req(s_p2),
    .p3_req(s_p3), .tx_hold(s_hold), .pstate(s_pstate), .req_timeout(s_tout)
`ifdef SLINK_PSTATE_STATS_EN
    , .p1_entries(s_e1), .p2_entries(s_e2), .p3_entries(s_e3),
    .timeout_count(s_tc)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 active, 1 requesting, 2 in Px, 3 exiting.
  int m_mode = 0, m_idle = 0, m_tgt = 0, m_reqc = 0;
  bit m_wake = 0, m_tout = 0;
  int m_ent[4];
  int m_tcnt = 0;
  int n_mode, n_idle, n_tgt, n_reqc;
  bit n_wake, n_tout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int best_state();
    int c = 0;
    for (int k = 1; k <= 3; k++) begin
      int th = (k == 1) ? int'(p1_th) : (k == 2) ? int'(p2_th) : int'(p3_th);
      if (k <= int'(cfg_max_state) && th != 0 && m_idle >= th) c = k;
    end
    return c;
  endfunction

  task automatic model_step();
    bit act = tx_sop | rx_valid | app_wake;
    bit leave = 0;
    n_mode = m_mode; n_idle = m_idle; n_tgt = m_tgt; n_reqc = m_reqc;
    n_wake = m_wake; n_tout = 0;
    if (link_reset) begin
      n_mode = 0; n_idle = 0; n_tgt = 0; n_reqc = 0; n_wake = 0;
      for (int k = 0; k < 4; k++) m_ent[k] = 0;
      m_tcnt = 0;
    end else if (in_reset_state) begin
      n_mode = 0; n_idle = 0; n_tgt = 0; n_reqc = 0; n_wake = 0;
    end else begin
      case (m_mode)
        0: begin
          int c = best_state();
          if (cfg_en && cfg_max_state != 0 && !act && c != 0) begin
            n_mode = 1; n_tgt = c; n_reqc = 0;
          end
        end
        1: begin
          if (act) n_wake = 1;
          if (!cfg_en) n_mode = 3;
          else if (in_px_state) begin
            n_mode = 2; m_ent[m_tgt]++;
          end else if (m_reqc == T - 1) begin
            n_mode = 0; n_tout = 1; n_wake = 0; leave = 1; m_tcnt++;
          end else n_reqc = m_reqc + 1;
        end
        2: if (app_wake || tx_sop || m_wake || !cfg_en) n_mode = 3;
        default: if (!in_px_state) begin n_mode = 0; n_wake = 0; leave = 1; end
      endcase
      if (act || !cfg_en || leave) n_idle = 0;
      else if (m_mode == 0 && m_idle < IDLE_MAX) n_idle = m_idle + 1;
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge link_clk);
    #1;
    m_mode = n_mode; m_idle = n_idle; m_tgt = n_tgt; m_reqc = n_reqc;
    m_wake = n_wake; m_tout = n_tout;
    check("p1_req", p1_req, (m_mode == 1 || m_mode == 2) && m_tgt == 1);
    check("p2_req", p2_req, (m_mode == 1 || m_mode == 2) && m_tgt == 2);
    check("p3_req", p3_req, (m_mode == 1 || m_mode == 2) && m_tgt == 3);
    check("tx_hold", tx_hold, m_mode != 0);
    check("pstate", pstate, (m_mode == 0) ? 0 : m_tgt);
    check("req_timeout", req_timeout, m_tout);
    check("onehot", $countones({p3_req, p2_req, p1_req}) <= 1, 1);
`ifdef SLINK_PSTATE_STATS_EN
    check("p1_entries", p1_entries, m_ent[1]);
    check("p2_entries", p2_entries, m_ent[2]);
    check("p3_entries", p3_entries, m_ent[3]);
    check("timeout_count", timeout_count, m_tcnt);
`endif
  endtask

  task automatic do_reset();
    link_reset = 1'b1;
    cyc();
    cyc();
    link_reset = 1'b0;
  endtask

  task automatic wait_any(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while ({p3_req, p2_req, p1_req} == 3'b000 && n < 200);
  endtask

  initial begin
    int n;
    bit any;

    // Reset state
    cfg_en = 1'b1; cfg_max_state = 2'd1; p1_th = 16'd10;
    do_reset();
    check("rst_reqs", {p3_req, p2_req, p1_req}, 0);
    check("rst_hold", tx_hold, 0);
    check("rst_pstate", pstate, 0);
    check("rst_tout", req_timeout, 0);

    // P1 entry and wake exit
    wait_any(n);
    check("p1_rise_cycles", n, 11);
    check("p1_only", {p3_req, p2_req, p1_req}, 3'b001);
    in_px_state = 1'b1;
    cyc(); cyc();
    check("p1_held_in_px", p1_req, 1);
    app_wake = 1'b1;
    cyc();
    app_wake = 1'b0;
    check("p1_drop", p1_req, 0);
    check("exit_hold", tx_hold, 1);
    in_px_state = 1'b0;
    cyc();
    check("exit_hold_fall", tx_hold, 0);
    check("exit_pstate", pstate, 0);

    // Priority with max = 2, timeout, re-idle
    p1_th = 16'd5; p2_th = 16'd20; p3_th = 16'd40; cfg_max_state = 2'd2;
    do_reset();
    wait_any(n);
    check("prio_p1_cycles", n, 6);
    check("prio_p1_only", {p3_req, p2_req, p1_req}, 3'b001);
    n = 0;
    do begin cyc(); n++; end while (!req_timeout && n < 100);
    check("tout_cycles", n, 16);
    check("tout_req_drop", {p3_req, p2_req, p1_req}, 0);
    cyc();
    check("tout_pulse_width", req_timeout, 0);
    wait_any(n);
    check("reidle_cycles", n, 5);
    check("reidle_p1_only", {p3_req, p2_req, p1_req}, 3'b001);

    // P3 only
    p1_th = 16'd0; p2_th = 16'd0; p3_th = 16'd40; cfg_max_state = 2'd3;
    do_reset();
    wait_any(n);
    check("p3_cycles", n, 41);
    check("p3_only", {p3_req, p2_req, p1_req}, 3'b100);

    // Wake during REQ
    p2_th = 16'd3; p3_th = 16'd0; cfg_max_state = 2'd2;
    do_reset();
    wait_any(n);
    check("p2_cycles", n, 4);
    check("p2_only", {p3_req, p2_req, p1_req}, 3'b010);
    cyc();
    tx_sop = 1'b1;
    cyc();
    tx_sop = 1'b0;
    check("p2_kept_on_wake", p2_req, 1);
    cyc(); cyc();
    in_px_state = 1'b1;
    cyc();
    check("p2_in_px", p2_req, 1);
    cyc();
    check("p2_pend_exit", p2_req, 0);
    check("p2_exit_hold", tx_hold, 1);
    in_px_state = 1'b0;
    cyc();
    check("p2_exit_done", tx_hold, 0);

    // Reset mid-operation
    p1_th = 16'd2; p2_th = 16'd0; cfg_max_state = 2'd1;
    do_reset();
    wait_any(n);
    in_px_state = 1'b1;
    cyc();
    check("mid_in_px", p1_req, 1);
    in_reset_state = 1'b1;
    cyc();
    in_reset_state = 1'b0;
    check("mid_reqs", {p3_req, p2_req, p1_req}, 0);
    check("mid_hold", tx_hold, 0);
    check("mid_pstate", pstate, 0);
`ifdef SLINK_PSTATE_STATS_EN
    check("mid_entries_kept", p1_entries, 1);
`endif
    in_px_state = 1'b0;

    // Activity suppression
    p1_th = 16'd10;
    do_reset();
    any = 0;
    for (int i = 0; i < 80; i++) begin
      rx_valid = (i % 8 == 7);
      cyc();
      any |= (p1_req | p2_req | p3_req);
    end
    rx_valid = 1'b0;
    check("suppress_no_req", any, 0);

    // Idle counter saturation on the 4-bit instance
    s_reset = 1'b1;
    cyc();
    s_reset = 1'b0;
    repeat (10) cyc();
    check("sat_cnt_10", u_sat.idle_cnt, 10);
    repeat (30) cyc();
    check("sat_cnt_hold", u_sat.idle_cnt, 15);
    check("sat_no_req", {s_p3, s_p2, s_p1}, 0);

    // Randomised operation
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        p1_th = 16'($urandom_range(0, 12));
        p2_th = 16'($urandom_range(0, 12));
        p3_th = 16'($urandom_range(0, 12));
        cfg_max_state = 2'($urandom_range(0, 3));
      end
      cfg_en         = ($urandom_range(0, 59) != 0);
      tx_sop         = ($urandom_range(0, 39) == 0);
      rx_valid       = ($urandom_range(0, 39) == 0);
      app_wake       = ($urandom_range(0, 79) == 0);
      in_reset_state = ($urandom_range(0, 299) == 0);
      if ((m_mode == 1 || m_mode == 2) && !in_px_state && $urandom_range(0, 11) == 0)
        in_px_state = 1'b1;
      else if ((m_mode == 0 || m_mode == 3) && in_px_state && $urandom_range(0, 2) == 0)
        in_px_state = 1'b0;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
